clock_counter: RTL and testbench

//  Fractional clock divider: derives a square-wave clock enable/strobe o_clk of

---
 rtl/clock_counter.sv | 52 +++++
 tb/tb_clock_counter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/clock_counter.sv
// Fractional clock divider: phase accumulator producing a registered
// square-wave strobe o_clk averaging F_CLK_OUT from an F_CLK_IN clock.
module clock_counter #(
  parameter int F_CLK_OUT = 48_000,
  parameter int F_CLK_IN  = 50_000_000
) (
  input  logic clk,
  input  logic i_rst,
  input  logic enable,
  output logic o_clk
);

  localparam int INC   = 2 * F_CLK_OUT;
  localparam int ACC_W = $clog2(F_CLK_IN + INC);

  localparam logic [ACC_W:0] INC_W = (ACC_W+1)'(INC);
  localparam logic [ACC_W:0] MOD_W = (ACC_W+1)'(F_CLK_IN);

  if (F_CLK_OUT <= 0 || INC > F_CLK_IN) begin : g_bad_ratio
    $error("clock_counter: need 0 < 2*F_CLK_OUT <= F_CLK_IN");
  end

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   nxt;
  logic             wrap;
  logic             unused_msb;

  // Extra bit keeps sum from overflowing before the compare.
  always_comb begin
    sum  = {1'b0, acc} + INC_W;
    wrap = (sum >= MOD_W);
    nxt  = wrap ? (sum - MOD_W) : sum;
  end

  assign unused_msb = nxt[ACC_W];

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      acc   <= '0;
      o_clk <= 1'b0;
    end else if (!enable) begin
      acc   <= '0;
      o_clk <= 1'b0;
    end else begin
      acc <= nxt[ACC_W-1:0];
      if (wrap)
        o_clk <= ~o_clk;
    end
  end

endmodule

// File: tb/tb_clock_counter.sv
// Directed bench for clock_counter: defaults plus small integer and
// fractional ratios, enable drop/restart and asynchronous reset.
module tb_clock_counter;

  logic clk = 1'b0;
  logic i_rst;
  logic en_def;
  logic en_s;
  logic o_def, o_a, o_b, o_c;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  clock_counter u_def (
    .clk(clk), .i_rst(i_rst), .enable(en_def), .o_clk(o_def)
  );

  clock_counter #(.F_CLK_OUT(2), .F_CLK_IN(8)) u_a (
    .clk(clk), .i_rst(i_rst), .enable(en_s), .o_clk(o_a)
  );

  clock_counter #(.F_CLK_OUT(3), .F_CLK_IN(10)) u_b (
    .clk(clk), .i_rst(i_rst), .enable(en_s), .o_clk(o_b)
  );

  clock_counter #(.F_CLK_OUT(2), .F_CLK_IN(4)) u_c (
    .clk(clk), .i_rst(i_rst), .enable(en_s), .o_clk(o_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected o_clk after enabled edges 1..12 (bit0 = edge 1).
  logic [11:0] exp_a = 12'b0110_0110_0110;
  logic [11:0] exp_b = 12'b1001_0011_0110;
  logic [11:0] exp_c = 12'b0101_0101_0101;

  initial begin
    int  last;
    int  toggles;
    int  bad;
    logic prev;

    i_rst  = 1'b0;
    en_def = 1'b1;
    en_s   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_def", o_def, 0);
      check("rst_b", o_b, 0);
    end

    en_def = 1'b0;
    en_s   = 1'b0;
    tick();
    i_rst = 1'b1;
    tick();
    check("idle_def", o_def, 0);
    check("idle_c", o_c, 0);

    en_def = 1'b1;
    en_s   = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("ratio4_e%0d", k), o_a, exp_a[k-1]);
      check($sformatf("ratio10_3_e%0d", k), o_b, exp_b[k-1]);
      check($sformatf("clk_div2_e%0d", k), o_c, exp_c[k-1]);
    end

    for (int k = 13; k <= 520; k++) tick();
    check("def_e520", o_def, 0);
    tick();
    check("def_first_toggle", o_def, 1);

    prev    = 1'b1;
    last    = 521;
    toggles = 1;
    bad     = 0;
    for (int k = 522; k <= 62500; k++) begin
      tick();
      if (o_def !== prev) begin
        if ((k - last) != 520 && (k - last) != 521) bad++;
        last    = k;
        toggles = toggles + 1;
        prev    = o_def;
      end
    end
    check("def_half_bad", bad, 0);
    check("def_toggles", toggles, 120);
    check("def_last_edge", last, 62500);
    check("def_level", o_def, 0);

    for (int k = 0; k < 700; k++) tick();
    check("def_mid_high", o_def, 1);
    en_def = 1'b0;
    tick();
    check("def_drop", o_def, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("def_off", o_def, 0);
    end
    en_def = 1'b1;
    for (int k = 0; k < 520; k++) tick();
    check("def_re_e520", o_def, 0);
    tick();
    check("def_re_first", o_def, 1);

    i_rst = 1'b0;
    #1;
    check("async_rst_def", o_def, 0);
    check("async_rst_a", o_a, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
